inst_fetch_unit: RTL and testbench

//  Fetch-side responder for the pc block. Accepts the pc address, reads the

---
 rtl/inst_fetch_unit.sv | 139 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Fetch-side responder for the pc block: fetches one instruction at a time over a
// req/ack memory handshake and queues {addr, inst} pairs for decode.
module inst_fetch_unit #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_Clk,
    input  logic              i_reset_n,
    input  logic [ADDR_W-1:0] i_pc_addr,
    output logic              o_pc_hold,
    input  logic              i_jump_flag,
    input  logic              i_hold_flag,
    output logic              o_rom_req,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic              i_rom_ack,
    input  logic [DATA_W-1:0] i_rom_data,
    output logic              o_inst_valid,
    output logic [DATA_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_inst_addr
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [DATA_W-1:0] NOP      = DATA_W'(32'h0000_0013);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              push;
    logic              pop;
    logic              full;

    logic [ADDR_W-1:0] rom_addr;

    logic [ADDR_W-1:0] buf_addr [DEPTH];
    logic [DATA_W-1:0] buf_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    assign full = (count == FULL_CNT);

    always_ff @(posedge i_Clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A jump coinciding with the ack retires the request but must not push stale data.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        push      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!i_jump_flag && !full) begin
                    accept    = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_rom_ack) begin
                    push      = !i_jump_flag;
                    state_nxt = S_IDLE;
                end else if (i_jump_flag) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (i_rom_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The request stays up through DROP so the memory never sees a withdrawn read.
    assign o_rom_req  = (state != S_IDLE);
    assign o_pc_hold  = (state != S_IDLE) || full;
    assign o_rom_addr = rom_addr;

    always_ff @(posedge i_Clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rom_addr <= '0;
        end else if (accept) begin
            rom_addr <= i_pc_addr;
        end
    end

    assign pop = (count != '0) && !i_hold_flag && !i_jump_flag;

    always_ff @(posedge i_Clk) begin
        if (push) begin
            buf_addr[wr_ptr] <= rom_addr;
            buf_data[wr_ptr] <= i_rom_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_Clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (i_jump_flag) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign o_inst_valid = (count != '0);
    assign o_inst       = o_inst_valid ? buf_data[rd_ptr] : NOP;
    assign o_inst_addr  = o_inst_valid ? buf_addr[rd_ptr] : '0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a behavioural pc and a variable-latency memory.
module tb_inst_fetch_unit;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              i_Clk;
    logic              i_reset_n;
    logic [ADDR_W-1:0] i_pc_addr;
    logic              o_pc_hold;
    logic              i_jump_flag;
    logic              i_hold_flag;
    logic              o_rom_req;
    logic [ADDR_W-1:0] o_rom_addr;
    logic              i_rom_ack;
    logic [DATA_W-1:0] i_rom_data;
    logic              o_inst_valid;
    logic [DATA_W-1:0] o_inst;
    logic [ADDR_W-1:0] o_inst_addr;

    inst_fetch_unit #(.DEPTH(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_Clk       (i_Clk),
        .i_reset_n   (i_reset_n),
        .i_pc_addr   (i_pc_addr),
        .o_pc_hold   (o_pc_hold),
        .i_jump_flag (i_jump_flag),
        .i_hold_flag (i_hold_flag),
        .o_rom_req   (o_rom_req),
        .o_rom_addr  (o_rom_addr),
        .i_rom_ack   (i_rom_ack),
        .i_rom_data  (i_rom_data),
        .o_inst_valid(o_inst_valid),
        .o_inst      (o_inst),
        .o_inst_addr (o_inst_addr)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          lat;
    int          mem_wait;
    logic [31:0] pc;
    logic [31:0] jtarget;
    logic [63:0] got_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return 32'hA000_0000 + a;
    endfunction

    task automatic chk_pop(input string tag, input int idx, input logic [31:0] addr);
        logic [63:0] got;
        got = (idx < got_q.size()) ? got_q[idx] : 64'hx;
        chk($sformatf("%s_%0d", tag, idx), got, {addr, inst_of(addr)});
    endtask

    // One clock: drive memory response, log the pop, then advance pc/memory models.
    task automatic cycle();
        logic hold_s, jump_s, req_s, ack_s;
        i_rom_ack  = o_rom_req && (mem_wait >= lat);
        i_rom_data = inst_of(o_rom_addr);
        hold_s = o_pc_hold;
        jump_s = i_jump_flag;
        req_s  = o_rom_req;
        ack_s  = i_rom_ack;
        if (o_inst_valid && !i_hold_flag && !i_jump_flag)
            got_q.push_back({o_inst_addr, o_inst});
        @(posedge i_Clk);
        @(negedge i_Clk);
        if (jump_s) pc = jtarget;
        else if (!hold_s) pc = pc + 32'd4;
        if (req_s && !ack_s) mem_wait++;
        else mem_wait = 0;
        i_pc_addr = pc;
        i_rom_ack = 1'b0;
    endtask

    task automatic model_clear();
        pc          = '0;
        jtarget     = '0;
        mem_wait    = 0;
        lat         = 0;
        got_q.delete();
        i_pc_addr   = '0;
        i_jump_flag = 1'b0;
        i_hold_flag = 1'b0;
        i_rom_ack   = 1'b0;
        i_rom_data  = '0;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        model_clear();
        repeat (2) @(negedge i_Clk);
        i_reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: reset values, then back-to-back fetches with 1-cycle memory
        do_reset();
        chk("rst_req",   64'(o_rom_req),    64'(0));
        chk("rst_addr",  64'(o_rom_addr),   64'(0));
        chk("rst_valid", 64'(o_inst_valid), 64'(0));
        chk("rst_inst",  64'(o_inst),       64'(NOP));
        chk("rst_iaddr", 64'(o_inst_addr),  64'(0));
        chk("rst_hold",  64'(o_pc_hold),    64'(0));
        for (int c = 0; c < 10; c++) begin
            if (c < 4) chk($sformatf("t1_pchold%0d", c), 64'(o_pc_hold), 64'(c % 2));
            cycle();
        end
        chk("t1_npop", 64'(got_q.size()), 64'(4));
        for (int i = 0; i < 4; i++) chk_pop("t1_pop", i, 32'(4 * i));

        // Test 2: hold fills the FIFO, release drains in order
        do_reset();
        i_hold_flag = 1'b1;
        repeat (20) cycle();
        chk("t2_pchold", 64'(o_pc_hold),    64'(1));
        chk("t2_valid",  64'(o_inst_valid), 64'(1));
        chk("t2_head",   64'(o_inst_addr),  64'(0));
        chk("t2_inst",   64'(o_inst),       64'(inst_of(32'h0)));
        chk("t2_req",    64'(o_rom_req),    64'(0));
        chk("t2_raddr",  64'(o_rom_addr),   64'(32'hC));
        chk("t2_nopop",  64'(got_q.size()), 64'(0));
        i_hold_flag = 1'b0;
        repeat (10) cycle();
        for (int i = 0; i < 4; i++) chk_pop("t2_pop", i, 32'(4 * i));

        // Test 3: jump during WAIT with slow memory goes through DROP
        do_reset();
        lat = 3;
        cycle();
        i_jump_flag = 1'b1;
        jtarget     = 32'h100;
        cycle();
        i_jump_flag = 1'b0;
        chk("t3_drop_req",  64'(o_rom_req),  64'(1));
        chk("t3_drop_addr", 64'(o_rom_addr), 64'(0));
        chk("t3_drop_hold", 64'(o_pc_hold),  64'(1));
        repeat (3) cycle();
        chk("t3_idle_req", 64'(o_rom_req),    64'(0));
        chk("t3_valid",    64'(o_inst_valid), 64'(0));
        chk("t3_nop",      64'(o_inst),       64'(NOP));
        chk("t3_iaddr",    64'(o_inst_addr),  64'(0));
        lat = 0;
        cycle();
        chk("t3_new_req",  64'(o_rom_req),  64'(1));
        chk("t3_new_addr", 64'(o_rom_addr), 64'(32'h100));
        repeat (3) cycle();
        chk_pop("t3_pop", 0, 32'h100);

        // Test 4: jump and ack together, with two entries queued
        do_reset();
        i_hold_flag = 1'b1;
        repeat (5) cycle();
        chk("t4_pre_valid", 64'(o_inst_valid), 64'(1));
        chk("t4_pre_req",   64'(o_rom_req),    64'(1));
        i_jump_flag = 1'b1;
        jtarget     = 32'h200;
        cycle();
        i_jump_flag = 1'b0;
        i_hold_flag = 1'b0;
        chk("t4_valid",  64'(o_inst_valid), 64'(0));
        chk("t4_pchold", 64'(o_pc_hold),    64'(0));
        chk("t4_req",    64'(o_rom_req),    64'(0));
        chk("t4_nop",    64'(o_inst),       64'(NOP));
        repeat (4) cycle();
        chk("t4_npop", 64'(got_q.size()), 64'(1));
        chk_pop("t4_pop", 0, 32'h200);

        // Test 5: push and pop on the same edge, long run across pointer wrap
        do_reset();
        for (int k = 0; k < 70; k++) begin
            i_hold_flag = (k < 7) ? 1'b1 : (k % 3 == 0);
            if (k == 7) begin
                chk("t5_pp_ack",  64'(o_rom_req),   64'(1));
                chk("t5_pp_head", 64'(o_inst_addr), 64'(0));
            end
            cycle();
            if (k == 7) begin
                chk("t5_pp_valid", 64'(o_inst_valid), 64'(1));
                chk("t5_pp_next",  64'(o_inst_addr),  64'(4));
            end
        end
        chk("t5_enough", 64'(got_q.size() >= 16), 64'(1));
        for (int i = 0; i < 16; i++) chk_pop("t5_pop", i, 32'(4 * i));

        // Test 6: asynchronous reset while a fetch is outstanding
        do_reset();
        i_hold_flag = 1'b1;
        cycle();
        cycle();
        lat = 3;
        cycle();
        chk("t6_pre_req",   64'(o_rom_req),    64'(1));
        chk("t6_pre_valid", 64'(o_inst_valid), 64'(1));
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("t6_req",   64'(o_rom_req),    64'(0));
        chk("t6_valid", 64'(o_inst_valid), 64'(0));
        chk("t6_inst",  64'(o_inst),       64'(NOP));
        chk("t6_hold",  64'(o_pc_hold),    64'(0));
        chk("t6_raddr", 64'(o_rom_addr),   64'(0));
        @(negedge i_Clk);
        model_clear();
        i_reset_n = 1'b1;
        cycle();
        chk("t6_re_req",  64'(o_rom_req),  64'(1));
        chk("t6_re_addr", 64'(o_rom_addr), 64'(0));
        repeat (3) cycle();
        chk_pop("t6_pop", 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
